mux9_rr_arbiter: RTL and testbench



---
 rtl/mux9_rr_arbiter_pkg.sv | 26 ++
 rtl/mux9_rr_arbiter_if.sv | 15 +
 rtl/mux9_rr_arbiter_rr_pick9.sv | 29 ++
 rtl/mux9_rr_arbiter.sv | 108 ++++++++++
 tb/tb_mux9_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux9_rr_arbiter_pkg.sv
// Purpose: shared types and encodings for the 9-requester round-robin mux arbiter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mux9_arb_pkg;

  localparam int NUM_REQ = 9;
  localparam int SEL_W   = 4;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Inputs 0..7 go through the 2:1 tree on s2..s0; input 8 is the bypass on s3
  // with the tree selects parked at zero.
  function automatic logic [SEL_W-1:0] idx_to_sel(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(8)) ? 4'b1000 : {1'b0, idx[2:0]};
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux9_rr_arbiter_if.sv
// Purpose: request/grant/select bundle between requesters and the 9:1 mux arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req until they see their gnt bit; no other flow control.
interface mux9_rr_arbiter_if;
  import mux9_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic [IDX_W-1:0]   owner;

  modport master (output req, input gnt, sel, busy, owner);
  modport slave  (input req, output gnt, sel, busy, owner);
endinterface

// File: rtl/mux9_rr_arbiter_rr_pick9.sv
// Purpose: combinational rotating-priority picker over 9 requests, starting at ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; valid is low when no request bit is set.
module rr_pick9
  import mux9_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan offsets from farthest to nearest so the nearest set bit at/above ptr wins.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mux9_rr_arbiter.sv
// Purpose: round-robin arbiter driving the selects of a 9:1 mux; optional MUX9_ARB_PRIO8_EN makes input 8 high priority.
// Latency: 1 cycle req->gnt from IDLE; every grant is followed by one GAP and one IDLE cycle.
// Backpressure: grant held until owner drops req or MAX_HOLD cycles elapse; mid-grant requests wait.
module mux9_rr_arbiter
  import mux9_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input logic             clk,
  input logic             rst_n,
  mux9_rr_arbiter_if.slave bus
);

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic               busy_q;
  logic [IDX_W-1:0]   owner_q;
  logic [HOLD_W-1:0]  cnt_q;
  logic [IDX_W-1:0]   ptr_q;

  logic               rr_vld;
  logic [IDX_W-1:0]   rr_idx;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic               preempt;
  logic               released;
  logic               hold_done;
  logic               grant_end;

  rr_pick9 u_rr (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (rr_vld),
    .idx   (rr_idx)
  );

`ifdef MUX9_ARB_PRIO8_EN
  logic             hp_vld;
  logic [IDX_W-1:0] hp_idx;

  // Same picker, masked to the bypass leg: its valid doubles as the preemption trigger.
  rr_pick9 u_hp (
    .req   (bus.req & {1'b1, {(NUM_REQ-1){1'b0}}}),
    .ptr   (IDX_W'(NUM_REQ-1)),
    .valid (hp_vld),
    .idx   (hp_idx)
  );

  assign pick_vld = rr_vld | hp_vld;
  assign pick_idx = hp_vld ? hp_idx : rr_idx;
  assign preempt  = hp_vld && (owner_q != IDX_W'(8));
`else
  assign pick_vld = rr_vld;
  assign pick_idx = rr_idx;
  assign preempt  = 1'b0;
`endif

  assign released  = !bus.req[owner_q];
  assign hold_done = (cnt_q == HOLD_W'(MAX_HOLD));
  assign grant_end = released | hold_done | preempt;

  // Arbitration FSM; all outputs are registered so the mux selects never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= GRANT;
            gnt_q   <= idx_to_onehot(pick_idx);
            owner_q <= pick_idx;
            sel_q   <= idx_to_sel(pick_idx);
            busy_q  <= 1'b1;
            cnt_q   <= HOLD_W'(1);
          end
        end
        GRANT: begin
          if (grant_end) begin
            // sel/owner stay put through GAP so the mux path is stable.
            state_q <= GAP;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= (owner_q == IDX_W'(8)) ? '0 : owner_q + IDX_W'(1);
          end else begin
            cnt_q   <= cnt_q + HOLD_W'(1);
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// Purpose: self-checking bench for mux9_rr_arbiter (directed steps plus randomized traffic vs a reference model).
// Latency: checks sampled 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_mux9_rr_arbiter;
  import mux9_arb_pkg::*;

  localparam int MAX_HOLD   = 4;
  localparam int HOLD_W     = 8;
  // Each foreign grant costs at most IDLE + MAX_HOLD + GAP cycles.
  localparam int WAIT_BOUND = 9 * (MAX_HOLD + 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux9_rr_arbiter_if bus ();

  mux9_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who holds the mux, for how long, and where the search starts next.
  int m_active, m_gap, m_last, m_run, m_next;

  // Statistics for the random phase.
  bit rand_phase = 0;
  int wait_cnt [9];
  int max_wait [9];
  int run_len, max_run;
  logic [8:0] prev_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_gap = 0; m_last = 0; m_run = 0; m_next = 0;
  endfunction

  function automatic void model_clock(input logic [8:0] r);
    int pick;
    bit rel;
    if (m_active != 0) begin
      rel = (r[m_last] == 1'b0) || (m_run == MAX_HOLD);
`ifdef MUX9_ARB_PRIO8_EN
      if (m_last != 8 && r[8]) rel = 1;
`endif
      if (rel) begin
        m_active = 0;
        m_gap    = 1;
        m_next   = (m_last + 1) % 9;
      end else begin
        m_run++;
      end
    end else if (m_gap != 0) begin
      m_gap = 0;
    end else begin
      pick = -1;
      for (int i = 0; i < 9; i++)
        if (pick < 0 && r[(m_next + i) % 9]) pick = (m_next + i) % 9;
`ifdef MUX9_ARB_PRIO8_EN
      if (r[8]) pick = 8;
`endif
      if (pick >= 0) begin
        m_active = 1; m_last = pick; m_run = 1;
      end
    end
  endfunction

  task automatic step();
    logic [8:0] eg;
    @(posedge clk);
    model_clock(bus.req);
    #1;
    eg = (m_active != 0) ? (9'd1 << m_last) : 9'd0;
    chk("gnt",   bus.gnt,   eg);
    chk("busy",  bus.busy,  m_active[0]);
    chk("owner", bus.owner, m_last);
    chk("sel",   bus.sel,   (m_last == 8) ? 4'b1000 : 4'(m_last));
    chk("onehot0", $onehot0(bus.gnt), 1);
    chk("sel_vs_owner", bus.sel, (bus.owner == 4'd8) ? 4'b1000 : {1'b0, bus.owner[2:0]});
    if (rand_phase) begin
      for (int k = 0; k < 9; k++) begin
        if (bus.gnt[k] || !bus.req[k]) wait_cnt[k] = 0;
        else wait_cnt[k]++;
        if (wait_cnt[k] > max_wait[k]) max_wait[k] = wait_cnt[k];
      end
      if (bus.gnt != 0 && bus.gnt == prev_gnt) run_len++;
      else if (bus.gnt != 0) run_len = 1;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      prev_gnt = bus.gnt;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    bus.req = '0;
    model_reset();
    #10 rst_n = 1'b1;
  endtask

  initial begin
    int exp_owner;
    int glen;
    logic prev_busy;

    rst_n   = 1'b0;
    bus.req = '0;
    model_reset();
    #12 rst_n = 1'b1;

    // Reset state.
    #1;
    chk("rst_gnt",   bus.gnt,   9'h000);
    chk("rst_sel",   bus.sel,   4'b0000);
    chk("rst_busy",  bus.busy,  1'b0);
    chk("rst_owner", bus.owner, 4'd0);

    // 1: single request, 1-cycle latency, then GAP with sel held.
    bus.req = 9'h001;
    step();
    chk("t1_gnt",  bus.gnt,  9'h001);
    chk("t1_sel",  bus.sel,  4'b0000);
    chk("t1_busy", bus.busy, 1'b1);
    bus.req = 9'h000;
    step();
    chk("t1_gap_gnt", bus.gnt, 9'h000);
    chk("t1_gap_sel", bus.sel, 4'b0000);
    step();

    // 2: all requesting, round-robin with timeout each grant.
    do_reset();
    bus.req   = 9'h1FF;
    exp_owner = 0;
    glen      = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 62; c++) begin
      step();
      if (bus.busy && !prev_busy) begin
        chk("t2_owner", bus.owner, exp_owner);
        exp_owner = (exp_owner + 1) % 9;
        glen = 1;
      end else if (bus.busy) begin
        glen++;
      end else if (prev_busy) begin
        chk("t2_len", glen, MAX_HOLD);
      end
      prev_busy = bus.busy;
    end

    // 3: inputs 5 and 8 alternate.
    do_reset();
    bus.req = 9'h120;
    step();
`ifndef MUX9_ARB_PRIO8_EN
    chk("t3_first", bus.sel, 4'b0101);
    step(); step();
    bus.req = 9'h100;
    step(); step(); step();
    chk("t3_second", bus.sel, 4'b1000);
    chk("t3_second_gnt", bus.gnt, 9'h100);
    bus.req = 9'h020;
    step(); step(); step();
    chk("t3_third", bus.sel, 4'b0101);
`else
    chk("t3_prio_first", bus.sel, 4'b1000);
    bus.req = 9'h020;
    step(); step(); step();
    chk("t3_prio_second", bus.sel, 4'b0101);
`endif
    bus.req = 9'h000;
    step(); step();

    // 4: asynchronous reset mid-grant of owner 3, pointer back to 0.
    do_reset();
    bus.req = 9'h008;
    step();
    chk("t4_owner", bus.owner, 4'd3);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_gnt",   bus.gnt,   9'h000);
    chk("t4_async_sel",   bus.sel,   4'b0000);
    chk("t4_async_busy",  bus.busy,  1'b0);
    chk("t4_async_owner", bus.owner, 4'd0);
    model_reset();
    bus.req = 9'h018;
    #3 rst_n = 1'b1;
    step();
    chk("t4_after_owner", bus.owner, 4'd3);
    chk("t4_after_gnt",   bus.gnt,   9'h008);

    // 5: request on input 8 while owner 2 holds the mux.
    do_reset();
    bus.req = 9'h004;
    step();
    chk("t5_owner", bus.owner, 4'd2);
    bus.req = 9'h104;
    step();
`ifdef MUX9_ARB_PRIO8_EN
    chk("t5_preempt_gap", bus.gnt, 9'h000);
    step(); step();
    chk("t5_gnt8", bus.gnt, 9'h100);
    chk("t5_sel8", bus.sel, 4'b1000);
`else
    chk("t5_keep1", bus.gnt, 9'h004);
    step();
    chk("t5_keep2", bus.gnt, 9'h004);
`endif

    // 6: randomized traffic with persistent request bits.
    do_reset();
    for (int k = 0; k < 9; k++) begin wait_cnt[k] = 0; max_wait[k] = 0; end
    run_len = 0; max_run = 0; prev_gnt = '0;
    rand_phase = 1;
    for (int c = 0; c < 10000; c++) begin
      logic [8:0] r;
      r = bus.req;
      for (int b = 0; b < 9; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      bus.req = r;
      step();
    end
    rand_phase = 0;
    chk("t6_max_hold", (max_run <= MAX_HOLD), 1);
    for (int k = 0; k < 9; k++) begin
`ifdef MUX9_ARB_PRIO8_EN
      if (k == 8) chk("t6_fair8", (max_wait[k] <= WAIT_BOUND), 1);
`else
      chk($sformatf("t6_fair%0d", k), (max_wait[k] <= WAIT_BOUND), 1);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
